// File: rtl/seg7_scan_ctrl.sv
// Scan controller for a common-anode multi-digit 7-segment display with a one-clock anode guard.
// Define SEG7_SCAN_LZB_EN to enable leading-zero blanking of the upper digits.
module seg7_scan_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [4*DIGITS-1:0] data,
    input  logic                load,
    input  logic                blank,
    output logic                ack,
    output logic                frame,
    output logic [6:0]          led,
    output logic [DIGITS-1:0]   an
);
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = $clog2(PRESCALE);
    localparam logic [DW-1:0] DIG_LAST  = DW'(DIGITS - 1);
    localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);

    typedef enum logic {GUARD, SHOW} state_t;

    state_t                state_reg, state_next;
    logic [DW-1:0]         dig_reg, dig_next;
    logic [PW-1:0]         pcnt_reg, pcnt_next;
    logic [4*DIGITS-1:0]   shadow_reg, shadow_next;
    logic                  ack_next, frame_next;
    logic [6:0]            led_next;
    logic [DIGITS-1:0]     an_next;
    logic [3:0]            nib_next [DIGITS];
    logic [DIGITS-1:0]     dig_dark;

    function automatic logic [6:0] hex2led(input logic [3:0] h);
        case (h)
            4'h0:    return 7'b1000000;
            4'h1:    return 7'b1111001;
            4'h2:    return 7'b0100100;
            4'h3:    return 7'b0110000;
            4'h4:    return 7'b0011001;
            4'h5:    return 7'b0010010;
            4'h6:    return 7'b0000010;
            4'h7:    return 7'b1111000;
            4'h8:    return 7'b0000000;
            4'h9:    return 7'b0010000;
            4'hA:    return 7'b0001000;
            4'hB:    return 7'b0000011;
            4'hC:    return 7'b1000110;
            4'hD:    return 7'b0100001;
            4'hE:    return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Slot sequencing: pcnt=0 is the guard clock, 1..PRESCALE-1 the lit part of the slot.
    always_comb begin
        state_next  = state_reg;
        dig_next    = dig_reg;
        pcnt_next   = pcnt_reg;
        shadow_next = shadow_reg;
        ack_next    = 1'b0;
        frame_next  = 1'b0;
        if (state_reg == GUARD) begin
            state_next = SHOW;
            pcnt_next  = pcnt_reg + 1'b1;
        end else if (pcnt_reg == PCNT_LAST) begin
            state_next = GUARD;
            pcnt_next  = '0;
            if (dig_reg == DIG_LAST) begin
                dig_next   = '0;
                frame_next = 1'b1;
                if (load) begin
                    shadow_next = data;
                    ack_next    = 1'b1;
                end
            end else begin
                dig_next = dig_reg + 1'b1;
            end
        end else begin
            pcnt_next = pcnt_reg + 1'b1;
        end
    end

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
        assign nib_next[gi] = shadow_next[4*gi +: 4];
    end

`ifdef SEG7_SCAN_LZB_EN
    // zero_from[i]: digit i and everything above it are zero.
    logic [DIGITS:0] zero_from;
    assign zero_from[DIGITS] = 1'b1;
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lzb
        assign zero_from[gi] = (nib_next[gi] == 4'h0) && zero_from[gi+1];
        assign dig_dark[gi]  = (gi != 0) && zero_from[gi];
    end
`else
    assign dig_dark = '0;
`endif

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_comb begin
        led_next = blank ? 7'h7F : hex2led(nib_next[dig_next]);
        an_next  = '1;
        if (!blank && state_next == SHOW && !dig_dark[dig_next]) begin
            an_next[dig_next] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= GUARD;
            dig_reg    <= '0;
            pcnt_reg   <= '0;
            shadow_reg <= '0;
            an         <= '1;
            led        <= 7'h7F;
            ack        <= 1'b0;
            frame      <= 1'b0;
        end else begin
            state_reg  <= state_next;
            dig_reg    <= dig_next;
            pcnt_reg   <= pcnt_next;
            shadow_reg <= shadow_next;
            an         <= an_next;
            led        <= led_next;
            ack        <= ack_next;
            frame      <= frame_next;
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl (DIGITS=4, PRESCALE=4): vector table plus reset and blanking sequences.
module tb_seg7_scan_ctrl;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] data;
    logic        load;
    logic        blank;
    logic        ack;
    logic        frame;
    logic [6:0]  led;
    logic [3:0]  an;

`ifdef SEG7_SCAN_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    seg7_scan_ctrl #(.DIGITS(4), .PRESCALE(4)) dut (
        .clk(clk), .reset_n(reset_n), .data(data), .load(load), .blank(blank),
        .ack(ack), .frame(frame), .led(led), .an(an)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic        bl;
        logic [15:0] dat;
        logic [3:0]  an;
        logic [6:0]  led;
        logic        ack;
        logic        frm;
    } vec_t;

    vec_t vecs[$];
    int   cyc;
    int   n_checks;
    int   n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cyc %0d: actual %h, required %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic [3:0] a, input logic [6:0] l,
                              input logic ak, input logic fr);
        check({name, ".an"}, 32'(an), 32'(a));
        check({name, ".led"}, 32'(led), 32'(l));
        check({name, ".ack"}, 32'(ack), 32'(ak));
        check({name, ".frame"}, 32'(frame), 32'(fr));
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic push(input logic ld, input logic bl, input logic [15:0] dat, input logic [3:0] a,
                        input logic [6:0] l, input logic ak, input logic fr);
        vec_t v;
        v.ld = ld; v.bl = bl; v.dat = dat; v.an = a; v.led = l; v.ack = ak; v.frm = fr;
        vecs.push_back(v);
    endtask

    // One full slot: guard clock then three lit clocks of digit d.
    task automatic slot(input logic ld, input logic [15:0] dat, input int d, input logic [6:0] l,
                        input logic ak, input logic fr, input bit lz_dark);
        logic [3:0] a_show;
        a_show = (lz_dark && LZB) ? 4'hF : (4'hF ^ (4'h1 << d));
        push(ld, 1'b0, dat, 4'hF, l, ak, fr);
        repeat (3) push(ld, 1'b0, dat, a_show, l, 1'b0, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0; load = 1'b0; blank = 1'b0; data = 16'h0000;
        cyc = 0; n_checks = 0; n_fail = 0;

        // Cycles 1..71 after reset release.
        repeat (3) push(1'b0, 1'b0, 16'h0000, 4'hE, 7'h40, 1'b0, 1'b0);
        slot(1'b0, 16'h0000, 1, 7'h40, 1'b0, 1'b0, 1'b1);
        slot(1'b1, 16'h1234, 2, 7'h40, 1'b0, 1'b0, 1'b1);
        slot(1'b1, 16'h1234, 3, 7'h40, 1'b0, 1'b0, 1'b1);
        slot(1'b1, 16'h1234, 0, 7'h19, 1'b1, 1'b1, 1'b0);
        slot(1'b0, 16'h1234, 1, 7'h30, 1'b0, 1'b0, 1'b0);
        slot(1'b1, 16'hA5F0, 2, 7'h24, 1'b0, 1'b0, 1'b0);
        slot(1'b1, 16'hA5F0, 3, 7'h79, 1'b0, 1'b0, 1'b0);
        slot(1'b1, 16'hA5F0, 0, 7'h40, 1'b1, 1'b1, 1'b0);
        slot(1'b1, 16'hA5F0, 1, 7'h0E, 1'b0, 1'b0, 1'b0);
        slot(1'b1, 16'hA5F0, 2, 7'h12, 1'b0, 1'b0, 1'b0);
        slot(1'b1, 16'hA5F0, 3, 7'h08, 1'b0, 1'b0, 1'b0);
        push(1'b1, 1'b0, 16'hA5F0, 4'hF, 7'h40, 1'b1, 1'b1);
        push(1'b0, 1'b0, 16'hA5F0, 4'hE, 7'h40, 1'b0, 1'b0);
        repeat (5) push(1'b0, 1'b1, 16'hA5F0, 4'hF, 7'h7F, 1'b0, 1'b0);
        push(1'b0, 1'b0, 16'hA5F0, 4'hD, 7'h0E, 1'b0, 1'b0);
        slot(1'b0, 16'hA5F0, 2, 7'h12, 1'b0, 1'b0, 1'b0);
        push(1'b0, 1'b0, 16'hA5F0, 4'hF, 7'h08, 1'b0, 1'b0);
        push(1'b0, 1'b0, 16'hA5F0, 4'h7, 7'h08, 1'b0, 1'b0);
        repeat (2) push(1'b0, 1'b1, 16'hA5F0, 4'hF, 7'h7F, 1'b0, 1'b0);
        push(1'b0, 1'b1, 16'hA5F0, 4'hF, 7'h7F, 1'b0, 1'b1);
        repeat (2) push(1'b0, 1'b1, 16'hA5F0, 4'hF, 7'h7F, 1'b0, 1'b0);
        push(1'b0, 1'b0, 16'hA5F0, 4'hE, 7'h40, 1'b0, 1'b0);
        slot(1'b0, 16'hA5F0, 1, 7'h0E, 1'b0, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        check_outs("reset", 4'hF, 7'h7F, 1'b0, 1'b0);
        reset_n = 1'b1;
        cyc = 0;

        foreach (vecs[j]) begin
            load = vecs[j].ld; blank = vecs[j].bl; data = vecs[j].dat;
            tick();
            check_outs("vec", vecs[j].an, vecs[j].led, vecs[j].ack, vecs[j].frm);
            $display("vec %0d cyc %0d load=%b blank=%b an=%b led=%b ack=%b frame=%b",
                     j, cyc, load, blank, an, led, ack, frame);
        end

        // Reset mid-frame while a load request is pending.
        load = 1'b1; data = 16'h7777;
        run_to(74);
        check_outs("pre_rst", 4'hB, 7'h12, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1 check_outs("mid_rst", 4'hF, 7'h7F, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check_outs("rst_hold", 4'hF, 7'h7F, 1'b0, 1'b0);
        load = 1'b0;
        reset_n = 1'b1;
        cyc = 0;
        run_to(1);
        check_outs("rel_c1", 4'hE, 7'h40, 1'b0, 1'b0);
        run_to(5);
        check_outs("rel_c5", LZB ? 4'hF : 4'hD, 7'h40, 1'b0, 1'b0);
        $display("seq mid-frame reset done at cyc %0d", cyc);

        // Leading-zero blanking sequence: 16'h0040 then 16'h0000.
        load = 1'b1; data = 16'h0040;
        run_to(16);
        check_outs("lz40_g0", 4'hF, 7'h40, 1'b1, 1'b1);
        load = 1'b0;
        run_to(17);
        check_outs("lz40_d0", 4'hE, 7'h40, 1'b0, 1'b0);
        run_to(21);
        check_outs("lz40_d1", 4'hD, 7'h19, 1'b0, 1'b0);
        run_to(25);
        check("lz40_d2.an", 32'(an), 32'(LZB ? 4'hF : 4'hB));
        run_to(29);
        check("lz40_d3.an", 32'(an), 32'(LZB ? 4'hF : 4'h7));
        $display("seq lzb 0040 done at cyc %0d", cyc);
        load = 1'b1; data = 16'h0000;
        run_to(32);
        check_outs("lz00_g0", 4'hF, 7'h40, 1'b1, 1'b1);
        load = 1'b0;
        run_to(33);
        check_outs("lz00_d0", 4'hE, 7'h40, 1'b0, 1'b0);
        run_to(37);
        check("lz00_d1.an", 32'(an), 32'(LZB ? 4'hF : 4'hD));
        run_to(41);
        check("lz00_d2.an", 32'(an), 32'(LZB ? 4'hF : 4'hB));
        run_to(45);
        check("lz00_d3.an", 32'(an), 32'(LZB ? 4'hF : 4'h7));
        $display("seq lzb 0000 done at cyc %0d", cyc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
